// File: rtl/cam_pattern_tx.sv
// Synthetic OV-style camera source: VSYNC/HREF/8-bit RGB565 stream (high byte first) with test patterns.
// Latency: every output is registered, one cycle behind the internal state/counters.
// Backpressure: none; free-running source paced only by cmos_pclk, enable is honoured at frame boundaries.
module cam_pattern_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 288,
    parameter int V_ACTIVE = 480,
    parameter int VS_LINES = 3,
    parameter int VB_LINES = 17,
    parameter int VF_LINES = 10
) (
    input  logic        cmos_pclk,
    input  logic        rst_133,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        cmos_vsyn,
    output logic        cmos_href,
    output logic [7:0]  cmos_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_LINES = VS_LINES + VB_LINES + V_ACTIVE + VF_LINES;
    localparam int BAR_W       = H_ACTIVE / 8;

    localparam logic [11:0] BCNT_LAST  = 12'(LINE_LEN - 1);
    localparam logic [11:0] HREF_END   = 12'(2 * H_ACTIVE);
    localparam logic [11:0] BAR_PX_END = 12'(BAR_W - 1);
    localparam logic [10:0] LCNT_LAST  = 11'(FRAME_LINES - 1);
    localparam logic [10:0] VS_LAST    = 11'(VS_LINES - 1);
    localparam logic [10:0] VB_LAST    = 11'(VS_LINES + VB_LINES - 1);
    localparam logic [10:0] VA_LAST    = 11'(VS_LINES + VB_LINES + V_ACTIVE - 1);
    localparam logic [10:0] ACT_FIRST  = 11'(VS_LINES + VB_LINES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    state_t      w_first_state;
    logic [11:0] r_bcnt;
    logic [10:0] r_lcnt;
    logic [11:0] r_bar_px;
    logic [2:0]  r_bar;
    logic [1:0]  r_pat;
    logic [15:0] r_solid;
    logic [15:0] r_fcnt;
    logic        r_end;

    logic        w_line_end;
    logic        w_frame_end;
    logic        w_start;
    logic        w_href;
    logic [10:0] w_x;
    logic [7:0]  w_y;
    logic [15:0] w_bar_rgb;
    logic [15:0] w_pix;

    assign w_line_end  = (r_bcnt == BCNT_LAST);
    assign w_frame_end = (r_state != ST_IDLE) && w_line_end && (r_lcnt == LCNT_LAST);
    assign w_start     = enable && ((r_state == ST_IDLE) || w_frame_end);
    assign w_href      = (r_state == ST_ACTIVE) && (r_bcnt < HREF_END);
    assign w_x         = r_bcnt[11:1];
    assign w_y         = 8'(r_lcnt - ACT_FIRST);

    // Entry state of a frame: zero-length sync/back-porch sections are skipped.
    always_comb begin
        w_first_state = ST_ACTIVE;
        if (VS_LINES > 0) begin
            w_first_state = ST_VSYNC;
        end else if (VB_LINES > 0) begin
            w_first_state = ST_VBACK;
        end
    end

    // State register.
    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: sections advance on the last byte of their last line.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_next_state = w_first_state;
            end
            ST_VSYNC: begin
                if (w_line_end && r_lcnt == VS_LAST) begin
                    if (VB_LINES > 0) w_next_state = ST_VBACK;
                    else              w_next_state = ST_ACTIVE;
                end
            end
            ST_VBACK: begin
                if (w_line_end && r_lcnt == VB_LAST) w_next_state = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_line_end && r_lcnt == VA_LAST) begin
                    if (VF_LINES > 0)  w_next_state = ST_VFRONT;
                    else if (enable)   w_next_state = w_first_state;
                    else               w_next_state = ST_IDLE;
                end
            end
            ST_VFRONT: begin
                if (w_frame_end) begin
                    if (enable) w_next_state = w_first_state;
                    else        w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Byte and line counters; held at zero while idle so every frame starts at line 0.
    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            r_bcnt <= '0;
            r_lcnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_bcnt <= '0;
            r_lcnt <= '0;
        end else if (w_line_end) begin
            r_bcnt <= '0;
            r_lcnt <= (r_lcnt == LCNT_LAST) ? '0 : r_lcnt + 11'd1;
        end else begin
            r_bcnt <= r_bcnt + 12'd1;
        end
    end

    // Colour-bar index tracked incrementally so no divider is needed for x/(H_ACTIVE/8).
    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            r_bar_px <= '0;
            r_bar    <= '0;
        end else if (r_state == ST_IDLE || w_line_end) begin
            r_bar_px <= '0;
            r_bar    <= '0;
        end else if (r_bcnt[0] && r_bcnt < HREF_END) begin
            if (r_bar_px == BAR_PX_END) begin
                r_bar_px <= '0;
                r_bar    <= r_bar + 3'd1;
            end else begin
                r_bar_px <= r_bar_px + 12'd1;
            end
        end
    end

    // Frame bookkeeping: pattern/solid latch at frame start, completion count and end flag.
    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            r_pat   <= '0;
            r_solid <= '0;
            r_fcnt  <= '0;
            r_end   <= 1'b0;
        end else begin
            r_end <= w_frame_end;
            if (w_frame_end) r_fcnt <= r_fcnt + 16'd1;
            if (w_start) begin
                r_pat   <= pattern_sel;
                // A back-to-back start coincides with the finishing frame being counted.
                r_solid <= (r_state == ST_IDLE) ? r_fcnt : r_fcnt + 16'd1;
            end
        end
    end

    // RGB565 colour-bar palette.
    always_comb begin
        w_bar_rgb = 16'h0000;
        case (r_bar)
            3'd0: w_bar_rgb = 16'hFFFF;
            3'd1: w_bar_rgb = 16'hFFE0;
            3'd2: w_bar_rgb = 16'h07FF;
            3'd3: w_bar_rgb = 16'h07E0;
            3'd4: w_bar_rgb = 16'hF81F;
            3'd5: w_bar_rgb = 16'hF800;
            3'd6: w_bar_rgb = 16'h001F;
            default: w_bar_rgb = 16'h0000;
        endcase
    end

    // Pixel value for the current byte position under the latched pattern.
    always_comb begin
        w_pix = 16'h0000;
        case (r_pat)
            2'd0:    w_pix = w_bar_rgb;
            2'd1:    w_pix = {5'd0, w_x};
            2'd2:    w_pix = {w_y, w_x[7:0]};
            default: w_pix = r_solid;
        endcase
    end

    // Registered sensor-side outputs.
    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            cmos_vsyn  <= 1'b0;
            cmos_href  <= 1'b0;
            cmos_data  <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= 16'h0000;
            busy       <= 1'b0;
        end else begin
            cmos_vsyn  <= (r_state == ST_VSYNC);
            cmos_href  <= w_href;
            cmos_data  <= w_href ? (r_bcnt[0] ? w_pix[7:0] : w_pix[15:8]) : 8'h00;
            frame_done <= r_end;
            frame_cnt  <= r_fcnt;
            busy       <= (r_state != ST_IDLE) || r_end;
        end
    end

endmodule

// File: tb/tb_cam_pattern_tx.sv
module tb_cam_pattern_tx;

    localparam int HA = 8;
    localparam int HB = 4;
    localparam int VA = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int LL = 2 * HA + HB;
    localparam int FL = (VS + VB + VA + VF) * LL;
    localparam int HN = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pat = 2'd0;
    logic        vsyn, href, done, busy;
    logic [7:0]  data;
    logic [15:0] fcnt;

    cam_pattern_tx #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .VS_LINES(VS), .VB_LINES(VB), .VF_LINES(VF)
    ) dut (
        .cmos_pclk(clk), .rst_133(rst_n), .enable(en), .pattern_sel(pat),
        .cmos_vsyn(vsyn), .cmos_href(href), .cmos_data(data),
        .frame_done(done), .frame_cnt(fcnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: a frame is FL byte slots; slot o -> (line o/LL, byte o%LL).
    int          m_slot = -1;
    int          m_prev = -1;
    logic [1:0]  m_pat = 2'd0;
    logic [15:0] m_solid = 16'd0;
    logic [15:0] m_fc = 16'd0;

    logic [7:0]  h_data [HN];
    logic        h_href [HN];
    logic        h_vsyn [HN];
    logic        h_done [HN];
    logic        h_busy [HN];
    logic [15:0] h_fc   [HN];
    logic [7:0]  bars   [16];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] bar_colour(input int i);
        case (i)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Returns {vsyn, href, data} for a frame slot.
    function automatic logic [9:0] ref_out(input int o, input logic [1:0] p, input logic [15:0] solid);
        int line = o / LL;
        int b = o % LL;
        int x = b / 2;
        int y = line - VS - VB;
        logic vs = (line < VS);
        logic act = (line >= VS + VB) && (line < VS + VB + VA) && (b < 2 * HA);
        logic [15:0] px;
        logic [7:0] d;
        case (p)
            2'd0:    px = bar_colour(x / (HA / 8));
            2'd1:    px = 16'(x);
            2'd2:    px = {8'(y), 8'(x)};
            default: px = solid;
        endcase
        d = act ? ((b % 2 == 0) ? px[15:8] : px[7:0]) : 8'h00;
        return {vs, act, d};
    endfunction

    task automatic step();
        logic [9:0] r;
        logic e_done, e_busy;
        @(posedge clk);
        cyc++;
        r = '0;
        e_done = 1'b0;
        e_busy = 1'b0;
        if (!rst_n) begin
            m_slot = -1; m_prev = -1; m_fc = 16'd0;
        end else begin
            e_done = (m_prev == FL - 1);
            if (e_done) m_fc = m_fc + 16'd1;
            e_busy = (m_slot >= 0) || e_done;
            if (m_slot >= 0) r = ref_out(m_slot, m_pat, m_solid);
            m_prev = m_slot;
            if (m_slot == -1 || m_slot == FL - 1) begin
                if (en) begin
                    m_solid = (m_slot == -1) ? m_fc : m_fc + 16'd1;
                    m_pat = pat;
                    m_slot = 0;
                end else begin
                    m_slot = -1;
                end
            end else begin
                m_slot++;
            end
        end
        #1;
        if (cyc < HN) begin
            h_data[cyc] = data; h_href[cyc] = href; h_vsyn[cyc] = vsyn;
            h_done[cyc] = done; h_busy[cyc] = busy; h_fc[cyc] = fcnt;
        end
        check("vsyn", {15'd0, vsyn}, {15'd0, r[9]});
        check("href", {15'd0, href}, {15'd0, r[8]});
        check("data", {8'd0, data}, {8'd0, r[7:0]});
        check("frame_done", {15'd0, done}, {15'd0, e_done});
        check("busy", {15'd0, busy}, {15'd0, e_busy});
        check("frame_cnt", fcnt, rst_n ? m_fc : 16'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy || m_slot != -1) && k < budget) begin
            step();
            k++;
        end
        check("idle_timeout", {15'd0, busy}, 16'd0);
    endtask

    function automatic int rise_of_href(input int e);
        for (int c = e + 1; c < e + 200 && c < HN; c++) begin
            if (h_href[c]) return c - e;
        end
        return -1;
    endfunction

    function automatic int href_count(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b && c < HN; c++) n += int'(h_href[c]);
        return n;
    endfunction

    task automatic check_bars(input string tag, input int base);
        for (int i = 0; i < 16; i++) check(tag, {8'd0, h_data[base + i]}, {8'd0, bars[i]});
    endtask

    int e0, e1, e2, e3, e4, e5, nb;

    initial begin
        bars = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

        // Reset state
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(2);

        // Timing, colour bars, back-to-back frames, solid frame count
        pat = 2'd0; en = 1'b1;
        step(); e0 = cyc;
        run(49);
        pat = 2'd3;
        run_to(e0 + 300);
        en = 1'b0;
        wait_idle(400);
        run(5);
        check("vsyn_before", {15'd0, h_vsyn[e0]}, 16'd0);
        check("vsyn_first", {15'd0, h_vsyn[e0 + 1]}, 16'd1);
        check("vsyn_last", {15'd0, h_vsyn[e0 + 20]}, 16'd1);
        check("vsyn_after", {15'd0, h_vsyn[e0 + 21]}, 16'd0);
        check("href_rise", 16'(rise_of_href(e0)), 16'd41);
        check_bars("bar_byte", e0 + 41);
        for (int f = 1; f <= 3; f++) begin
            check("done_cycle", {15'd0, h_done[e0 + 140 * f + 1]}, 16'd1);
            check("done_fcnt", h_fc[e0 + 140 * f + 1], 16'(f));
        end
        nb = 0;
        for (int c = e0 + 1; c <= e0 + 421; c++) nb += int'(!h_busy[c]);
        check("busy_gap", 16'(nb), 16'd0);
        check("solid_hi", {8'd0, h_data[e0 + 181]}, 16'h0000);
        check("solid_lo", {8'd0, h_data[e0 + 182]}, 16'h0001);

        // XY pattern, single frame
        pat = 2'd2; en = 1'b1;
        step(); e1 = cyc;
        en = 1'b0; pat = 2'($urandom_range(0, 3));
        wait_idle(400);
        run(3);
        check("xy_l3p5_hi", {8'd0, h_data[e1 + 111]}, 16'h0003);
        check("xy_l3p5_lo", {8'd0, h_data[e1 + 112]}, 16'h0005);
        check("xy_href_cnt", 16'(href_count(e1, e1 + 145)), 16'd64);

        // Enable dropped mid-frame
        pat = 2'($urandom_range(0, 3)); en = 1'b1;
        step(); e2 = cyc;
        run_to(e2 + 60);
        en = 1'b0;
        wait_idle(400);
        run(6);
        check("drop_href_cnt", 16'(href_count(e2, e2 + 146)), 16'd64);
        check("drop_done", {15'd0, h_done[e2 + 141]}, 16'd1);
        check("drop_busy_after", {15'd0, h_busy[e2 + 143]}, 16'd0);
        check("drop_vsyn_after", {15'd0, h_vsyn[e2 + 143]}, 16'd0);

        // pattern_sel change mid-line
        pat = 2'd1; en = 1'b1;
        step(); e3 = cyc;
        run(49);
        pat = 2'd0;
        run_to(e3 + 200);
        en = 1'b0;
        wait_idle(400);
        for (int i = 0; i < 16; i++)
            check("ramp_byte", {8'd0, h_data[e3 + 41 + i]}, (i % 2 == 1) ? 16'(i / 2) : 16'd0);
        check_bars("next_bar_byte", e3 + 181);

        // Randomized runs with pattern churn and random enable drop
        for (int r = 0; r < 4; r++) begin
            int len;
            pat = 2'($urandom_range(0, 3)); en = 1'b1;
            step();
            len = int'($urandom_range(1, 350));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) pat = 2'($urandom_range(0, 3));
                step();
            end
            en = 1'b0;
            wait_idle(400);
            run(int'($urandom_range(0, 5)));
        end

        // Asynchronous reset with HREF high, then restart
        pat = 2'd0; en = 1'b1;
        step(); e4 = cyc;
        run(44);
        check("pre_rst_href", {15'd0, href}, 16'd1);
        #2 rst_n = 1'b0;
        m_slot = -1; m_prev = -1; m_fc = 16'd0;
        #1;
        check("arst_vsyn", {15'd0, vsyn}, 16'd0);
        check("arst_href", {15'd0, href}, 16'd0);
        check("arst_data", {8'd0, data}, 16'd0);
        check("arst_done", {15'd0, done}, 16'd0);
        check("arst_busy", {15'd0, busy}, 16'd0);
        check("arst_fcnt", fcnt, 16'd0);
        en = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(2);
        en = 1'b1;
        step(); e5 = cyc;
        run(60);
        en = 1'b0;
        wait_idle(400);
        run(3);
        check("restart_href_rise", 16'(rise_of_href(e5)), 16'd41);
        check("restart_vsyn_first", {15'd0, h_vsyn[e5 + 1]}, 16'd1);
        check_bars("restart_bar_byte", e5 + 41);
        check("restart_done", {15'd0, h_done[e5 + 141]}, 16'd1);
        check("restart_fcnt", h_fc[e5 + 141], 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cam_pattern_tx.md
Name: cam_pattern_tx

Overview:
Synthetic CMOS-sensor transmitter. It drives the same VSYNC/HREF/8-bit byte-stream protocol that the camera receive path consumes, in RGB565 with the high byte first, one byte per cmos_pclk.
It substitutes for the physical OV-style camera during bring-up and regression of the capture → SDRAM → VGA chain.
It generates programmable frame timing and selectable test patterns, and reports frame completion.

Parameters:
H_ACTIVE, 640, active pixels per line; must be a multiple of 8; one line carries 2*H_ACTIVE bytes.
H_BLANK, 288, pclk cycles per line with HREF low, appended after the active bytes.
V_ACTIVE, 480, active lines per frame.
VS_LINES, 3, lines with VSYNC high at frame start.
VB_LINES, 17, back-porch lines between VSYNC and the first active line.
VF_LINES, 10, front-porch lines after the last active line.

Ports:
cmos_pclk  in  1  byte clock; all logic is on the rising edge.
rst_133  in  1  reset, asynchronous, active-low.
enable  in  1  level; frames stream while high.
pattern_sel  in  2  0 colour bars, 1 column ramp, 2 XY, 3 solid frame-count.
cmos_vsyn  out  1  frame sync, active high.
cmos_href  out  1  line-valid, high during active bytes.
cmos_data  out  8  pixel byte.
frame_done  out  1  one-cycle pulse at the end of each frame.
frame_cnt  out  16  completed-frame counter; wraps at 16'hFFFF → 0.
busy  out  1  high from frame start until frame end.

Behaviour:
- Reset (asynchronous): state IDLE; all counters 0; cmos_vsyn, cmos_href, frame_done and busy are 0; cmos_data is 8'h00; frame_cnt is 0.
- Counters:
  - LINE_LEN = 2*H_ACTIVE + H_BLANK.
  - FRAME_LINES = VS_LINES + VB_LINES + V_ACTIVE + VF_LINES.
  - bcnt counts 0..LINE_LEN-1. lcnt counts 0..FRAME_LINES-1 and increments when bcnt wraps.
- States:
  - IDLE → VSYNC when enable is sampled at 1. The pattern_sel latch is loaded on that same edge.
  - VSYNC → VBACK after VS_LINES lines.
  - VBACK → ACTIVE after VB_LINES lines.
  - ACTIVE → VFRONT after V_ACTIVE lines.
  - At the last byte of the last VFRONT line: go to VSYNC if enable=1 (re-latch pattern_sel), otherwise go to IDLE.
  - VS_LINES=0, VB_LINES=0 or VF_LINES=0 skips that state.
- Outputs are registered, so each output reflects the state/counters of the previous cycle. Latency from enable sampled high in IDLE to cmos_vsyn=1 is exactly 1 cycle.
- cmos_vsyn is 1 for all LINE_LEN cycles of each VSYNC line, otherwise 0.
- cmos_href is 1 only in ACTIVE with bcnt < 2*H_ACTIVE. Each line gives exactly 2*H_ACTIVE consecutive high cycles.
- Pixel coordinates: x = bcnt>>1, y = active line index 0..V_ACTIVE-1.
  - bcnt[0]=0 sends pixel[15:8]; bcnt[0]=1 sends pixel[7:0].
  - cmos_data is 8'h00 whenever cmos_href=0.
- Patterns (pixel value):
  - 0, colour bars: bar = x/(H_ACTIVE/8). Bars 0..7 are FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1, column ramp: x[15:0], zero-extended.
  - 2, XY: {y[7:0], x[7:0]}, truncated.
  - 3, solid: the frame_cnt value latched at frame start.
- frame_done is 1 for one cycle, the cycle after the last byte of the frame. frame_cnt increments on that same cycle.
- busy is 1 from the first VSYNC output cycle through the frame_done cycle. It stays 1 across back-to-back frames.
- Enable dropped mid-frame: the current frame completes unchanged, then the block enters IDLE. There is no truncated frame.
- pattern_sel changing mid-frame has no effect until the next frame start.
- rst_133 asserted mid-frame: outputs are 0 immediately (asynchronous). The next frame begins from lcnt=0 after enable is sampled high.
- Counter widths: bcnt is 12 bits and lcnt is 11 bits, sufficient for the defaults. No counter may overflow for legal parameters.

Test Plan:
Bench parameters for all scenarios unless stated: H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VS=1, VB=1, VF=1, giving LINE_LEN=20 and a 140-cycle frame.
1. Reset, then enable=1, pattern 0 → cmos_vsyn high for 20 cycles starting 1 cycle after enable is sampled. The first HREF rises at cycle 41. Active line bytes are FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
2. Pattern 2, one frame → 4 lines of 16 HREF-high cycles each. Line 3, pixel 5 is bytes 03 05. cmos_data=00 during blanking.
3. enable held high for 3 frames → frame_done pulses at cycles 141, 281 and 421. frame_cnt goes 1, 2, 3. busy stays high with no gap. With pattern 3, the frame-2 pixels are 00 01.
4. enable dropped at cycle 60 → the frame completes with all 4 active lines, frame_done fires, then cmos_vsyn, cmos_href and busy stay 0.
5. pattern_sel changed 1→0 during an active line → the current frame stays a ramp (bytes 00 00 00 01 … 00 07). The next frame is colour bars.
6. rst_133 pulsed low mid-line with HREF high → all outputs 0 asynchronously. frame_cnt=0 after reset. A restart with enable=1 reproduces scenario 1 timing exactly.
